// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } md_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself and is then read as unsigned.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 divide step on a packed {remainder, quotient} word.
module div_iter_step (
  input  logic [63:0] rq,
  input  logic [31:0] divisor,
  output logic [63:0] rq_next
);

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        fits;

  // Shifting {rem, quot} left by one brings the next dividend bit into the remainder.
  assign rem_shift = rq[63:31];
  assign diff      = rem_shift - {1'b0, divisor};
  assign fits      = rem_shift >= {1'b0, divisor};

  always_comb begin
    rq_next = {rem_shift[31:0], rq[30:0], 1'b0};
    if (fits) begin
      rq_next = {diff[31:0], rq[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: stalls EX for 32 iterations, then writes HI/LO once.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall,
  output logic        hi_we,
  output logic [31:0] hi_o,
  output logic        lo_we,
  output logic [31:0] lo_o
);

  localparam logic [4:0] LastCount = 5'(ITER - 1);

  md_state_e   state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [63:0] work_q, work_d;
  logic [4:0]  count_q, count_d;

  logic        in_signed;
  logic        accept;
  logic        is_div;
  logic        neg_res;
  logic [63:0] div_in;
  logic [63:0] div_next;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign in_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
  assign accept    = (state_q == StIdle) && op_valid && !cancel;
  assign is_div    = (op_q == MD_OP_DIV) || (op_q == MD_OP_DIVU);
  // Sign flags are only ever set for signed ops, so this covers MULT and DIV alike.
  assign neg_res   = sign_a_q ^ sign_b_q;

  assign stall = op_valid && !cancel && (state_q != StDone);

  // The work register is cleared at accept; the dividend is folded in on the first step.
  assign div_in   = (count_q == 5'd0) ? {32'd0, mag_a_q} : work_q;
  assign mul_next = {work_q[62:0], 1'b0} + {32'd0, (mag_b_q[~count_q] ? mag_a_q : 32'd0)};

  div_iter_step u_div_step (
    .rq      (div_in),
    .divisor (mag_b_q),
    .rq_next (div_next)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    work_d   = work_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StRun;
          op_d     = op;
          sign_a_d = in_signed & src_a[31];
          sign_b_d = in_signed & src_b[31];
          mag_a_d  = md_mag(src_a, in_signed & src_a[31]);
          mag_b_d  = md_mag(src_b, in_signed & src_b[31]);
          work_d   = 64'd0;
          count_d  = 5'd0;
        end
      end
      StRun: begin
        work_d  = is_div ? div_next : mul_next;
        count_d = count_q + 5'd1;
        if (count_q == LastCount) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (cancel) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= MD_OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      work_q   <= 64'd0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      work_q   <= work_d;
      count_q  <= count_d;
    end
  end

  assign prod_fix = neg_res ? (~work_q + 64'd1) : work_q;
  assign quot_fix = neg_res ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix  = sign_a_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_o  = 32'd0;
    lo_o  = 32'd0;
    if (state_q == StDone) begin
      hi_we = !cancel;
      lo_we = !cancel;
      if (is_div) begin
        hi_o = rem_fix;
        lo_o = quot_fix;
      end else begin
        {hi_o, lo_o} = prod_fix;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO, a monitor checks writes.
module tb_mul_div_unit;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stall;
  logic        hi_we;
  logic [31:0] hi_o;
  logic        lo_we;
  logic [31:0] lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mul_div_unit u_dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .stall    (stall),
    .hi_we    (hi_we),
    .hi_o     (hi_o),
    .lo_we    (lo_we),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every HI/LO write must match the oldest outstanding expectation and its cycle.
  always @(negedge clk) begin
    if (hi_we || lo_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got hi=%h lo=%h we=%b%b, expected no write (cycle %0d)",
                 hi_o, lo_o, hi_we, lo_we, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("we_pair", {62'd0, hi_we, lo_we}, 64'd3);
        check("hi", {32'd0, hi_o}, {32'd0, e.hi});
        check("lo", {32'd0, lo_o}, {32'd0, e.lo});
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Call just after a rising edge; returns at the falling edge of the DONE cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    int  n;
    bit  done;
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    exp_q.push_back('{hi: hi, lo: lo, cyc: cyc + 33});
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
      if (n == 5) begin
        src_a = ~a;
        src_b = b + 32'd1;
      end
    end
    check("stall_cycles", 64'(n), 64'd33);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    cancel   = 1'b0;
    op       = 2'b00;
    src_a    = 32'd0;
    src_b    = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    next_cycle();
    rst = 1'b0;

    next_cycle(); run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    next_cycle(); op_valid = 1'b0;
    next_cycle(); run_op(OpMult,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    next_cycle(); run_op(OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    next_cycle(); run_op(OpMult,  32'd5,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2);
    next_cycle(); run_op(OpMultu, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780);
    next_cycle(); run_op(OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    next_cycle(); run_op(OpDiv,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    next_cycle(); run_op(OpDivu,  32'd7,        32'd2,        32'd1,        32'd3);
    next_cycle(); run_op(OpDivu,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    next_cycle(); run_op(OpDiv,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001);
    next_cycle(); run_op(OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Cancel at RUN count 10, then a new op accepted the very next cycle.
    next_cycle();
    op_valid = 1'b1; op = OpDivu; src_a = 32'd50; src_b = 32'd3;
    repeat (11) next_cycle();
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_run_stall", {63'd0, stall}, 64'd0);
    check("cancel_run_we", {62'd0, hi_we, lo_we}, 64'd0);
    next_cycle();
    cancel = 1'b0;
    run_op(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);

    // Back-to-back with op_valid held across the boundary.
    next_cycle(); run_op(OpMultu, 32'd3, 32'd4, 32'd0, 32'd12);
    next_cycle(); run_op(OpDivu,  32'd9, 32'd3, 32'd0, 32'd3);
    next_cycle(); op_valid = 1'b0;

    // Cancel in DONE suppresses the write.
    next_cycle();
    op_valid = 1'b1; op = OpMultu; src_a = 32'd2; src_b = 32'd2;
    repeat (33) next_cycle();
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_done_we", {62'd0, hi_we, lo_we}, 64'd0);
    next_cycle();
    cancel = 1'b0; op_valid = 1'b0;

    // Cancel in IDLE blocks accept.
    next_cycle();
    op_valid = 1'b1; cancel = 1'b1; op = OpMultu; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    check("cancel_idle_stall", {63'd0, stall}, 64'd0);
    next_cycle();
    op_valid = 1'b0; cancel = 1'b0;
    repeat (40) next_cycle();

    // Reset mid-RUN discards the operation.
    op_valid = 1'b1; op = OpMultu; src_a = 32'd7; src_b = 32'd7;
    repeat (15) next_cycle();
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    check("rst_run_stall", {63'd0, stall}, 64'd0);
    check("rst_run_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_run_we", {62'd0, hi_we, lo_we}, 64'd0);
    next_cycle();
    rst = 1'b0;
    repeat (40) next_cycle();
    run_op(OpDivu, 32'd7, 32'd2, 32'd1, 32'd3);
    next_cycle(); op_valid = 1'b0;
    repeat (3) next_cycle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU; sits in the EX stage.
- Accepts operands from EX, stalls the pipeline while it iterates, then drives hi/lo write strobes and data into the HI/LO register (hilo_reg) in a single result cycle.
- Multiply and divide share one counter and one 64-bit working register.

Parameters:
- ITER, 32: iterations per operation; equals the operand width. Not intended to be changed.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- op_valid  in  1  EX holds a mul/div instruction; held high while stall is high
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand: multiplicand or dividend
- src_b  in  32  rt operand: multiplier or divisor
- cancel  in  1  flush from exception/redirect; aborts any operation
- stall  out  1  hold pipeline; combinational
- hi_we  out  1  HI write strobe, one cycle
- hi_o  out  32  HI data
- lo_we  out  1  LO write strobe, one cycle
- lo_o  out  32  LO data

Behaviour:
- States:
  - IDLE -> RUN on accept, where accept = op_valid & !cancel in IDLE.
  - RUN -> DONE after 32 iterations (count 0..31).
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE when cancel is high.
- Accept cycle T:
  - Latch op, the sign flags of both operands, and the operand magnitudes.
  - For signed ops, magnitude = two's-complement absolute value; 0x80000000 stays 0x80000000 and is treated as unsigned.
  - Clear the 64-bit work register and set count = 0.
- RUN, cycles T+1..T+32, one iteration per cycle:
  - Multiply: shift-add on magnitudes into the 64-bit product.
  - Divide: restoring radix-2 on {rem, quot}; shift left 1, trial-subtract the divisor from the upper 33 bits, keep the result if non-negative, and set the quotient bit.
- DONE at cycle T+33:
  - hi_we = lo_we = 1; hilo_reg captures the result at the end of T+33.
  - MULT/MULTU: {hi_o, lo_o} = product, negated (64-bit) if the signed op has differing signs.
  - DIV/DIVU: lo_o = quotient, hi_o = remainder.
  - DIV sign fix: quotient negated if sign_a ^ sign_b; remainder takes the sign of src_a.
- Stall:
  - stall = op_valid & !cancel & (state != DONE).
  - It is high in the accept cycle and throughout RUN, and low in DONE so the instruction leaves EX.
- Latency: 34 cycles from accept to writeback visible in HI/LO.
- Outputs outside DONE: hi_we = lo_we = 0 and hi_o = lo_o = 0.
- Divide by zero (defined, no trap):
  - DIVU: lo = 0xFFFFFFFF, hi = src_a.
  - DIV: lo = 0xFFFFFFFF if src_a >= 0, else 0x00000001; hi = src_a.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Cancel:
  - In RUN: state -> IDLE next cycle; no write.
  - In DONE: hi_we/lo_we forced to 0 in that cycle.
  - In IDLE with op_valid: no accept.
- Back-to-back: a new op_valid in the cycle after DONE is accepted normally; there is no bubble requirement.
- Reset: state IDLE, count 0, work register 0, all outputs 0. rst takes priority over cancel and op_valid; rst mid-RUN discards the operation with no write.
- Operands are sampled only at accept; changes on src_a/src_b during RUN are ignored.

Decomposition:
- Shared package (lib/defines.vh):
  - MD_OP_* encodings (MULT, MULTU, DIV, DIVU).
  - MD_ST_IDLE/RUN/DONE state encodings.
  - MD_ITER = 32.
- One natural sub-module, div_iter_step: a combinational single restoring step.
  - Inputs: 64-bit {rem, quot} and 32-bit divisor.
  - Output: next 64-bit {rem, quot}.
- Multiply step, sign fix and FSM stay inline in mul_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, accept at T -> stall high T..T+32, hi_we/lo_we only at T+33, hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7 / 2 -> lo = 3, hi = 1.
- DIVU 5 / 0 -> lo = 0xFFFFFFFF, hi = 5; DIV 0xFFFFFFF9 / 0 -> lo = 1, hi = 0xFFFFFFF9; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- cancel at RUN count 10 -> no we, state IDLE next cycle; a new DIVU 100 / 7 accepted the following cycle -> lo = 14, hi = 2 at its T+33.
- rst mid-RUN -> all outputs 0, no we, stall low once op_valid drops.
- Back-to-back MULTU 3 x 4 then DIVU 9 / 3, op_valid held -> two separate DONE cycles writing (0, 12) then (0, 3).
